// File: rtl/ins_word_loader_if.sv
// Field-set handshake and byte-wide instruction-memory write bus for
// ins_word_loader. The loader takes the slave side; the producer of field
// sets (and observer of the memory bus) takes the master side.
interface ins_word_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        fmt;
  logic [5:0]        opCode;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        sa;
  logic [15:0]       Immediate;
  logic [25:0]       j_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    output in_valid, fmt, opCode, rs, rt, rd, sa, Immediate, j_addr,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, fmt, opCode, rs, rt, rd, sa, Immediate, j_addr,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ins_word_loader.sv
// Packs R/I/J instruction fields into a 32-bit word and writes it big-endian,
// one byte per cycle, into byte-addressed instruction memory. One word per
// 6 cycles; the write pointer auto-increments modulo 2^ADDR_W.
// Optional: define INS_LOADER_WORDCNT_EN to add a saturating word_cnt output.
module ins_word_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                clr,
  ins_word_loader_if.slave    bus,
  output logic [31:0]         word_out,
  output logic                done,
`ifdef INS_LOADER_WORDCNT_EN
  output logic [15:0]         word_cnt,
`endif
  output logic                err
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] INC  = ADDR_W'(1);

  typedef enum logic [2:0] {IDLE, WR0, WR1, WR2, WR3, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       packed_word;
  logic              pack_err;
  logic [ADDR_W-1:0] start_addr;

  // Field packing by format; reserved format yields a zero word and flags err
  always_comb begin
    packed_word = 32'h0;
    pack_err    = 1'b0;
    case (bus.fmt)
      2'd0:    packed_word = {bus.opCode, bus.rs, bus.rt, bus.rd, bus.sa, 6'b0};
      2'd1:    packed_word = {bus.opCode, bus.rs, bus.rt, bus.Immediate};
      2'd2:    packed_word = {bus.opCode, bus.j_addr};
      default: begin
        packed_word = 32'h0;
        pack_err    = 1'b1;
      end
    endcase
  end

  // A clr in the accept cycle takes effect before the word's first byte
  always_comb begin
    start_addr = clr ? BASE : ptr;
  end

  // Loader FSM: byte 0 is launched at the accept edge so bytes land at T+1..T+4;
  // ptr always holds the address of the next byte to write
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= 8'h0;
      word_out      <= 32'h0;
      done          <= 1'b0;
      err           <= 1'b0;
      ptr           <= BASE;
`ifdef INS_LOADER_WORDCNT_EN
      word_cnt      <= 16'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            word_out      <= packed_word;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= start_addr;
            bus.mem_wdata <= packed_word[31:24];
            ptr           <= start_addr + INC;
            bus.in_ready  <= 1'b0;
            err           <= (err & ~clr) | pack_err;
            state         <= WR0;
          end else if (clr) begin
            ptr <= BASE;
            err <= 1'b0;
          end
`ifdef INS_LOADER_WORDCNT_EN
          if (clr) word_cnt <= 16'h0;
`endif
        end
        WR0: begin
          bus.mem_addr  <= ptr;
          bus.mem_wdata <= word_out[23:16];
          ptr           <= ptr + INC;
          state         <= WR1;
        end
        WR1: begin
          bus.mem_addr  <= ptr;
          bus.mem_wdata <= word_out[15:8];
          ptr           <= ptr + INC;
          state         <= WR2;
        end
        WR2: begin
          bus.mem_addr  <= ptr;
          bus.mem_wdata <= word_out[7:0];
          ptr           <= ptr + INC;
          state         <= WR3;
        end
        WR3: begin
          bus.mem_we <= 1'b0;
          done       <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          done         <= 1'b0;
          bus.in_ready <= 1'b1;
          state        <= IDLE;
`ifdef INS_LOADER_WORDCNT_EN
          if (word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
`endif
        end
        default: begin
          bus.mem_we   <= 1'b0;
          done         <= 1'b0;
          bus.in_ready <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
